// File: rtl/voice_alloc_pkg.sv
// Shared types for the voice allocator.
//   alloc_state_t : allocator FSM states
//   alloc_cat_t   : scan category chosen at commit time
//   MIDI_W        : width of a MIDI data byte (key / velocity)
package voice_alloc_pkg;
  localparam int MIDI_W = 8;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} alloc_state_t;
  typedef enum logic [2:0] {CAT_NONE, CAT_RETRIG, CAT_FREE, CAT_REL, CAT_STEAL} alloc_cat_t;
endpackage

// File: rtl/voice_popcount.sv
// Combinational population count of the per-voice gate vector.
//   i_vec : VOICES-bit vector
//   o_cnt : number of set bits (V_WIDTH+1 bits so a full vector fits)
module voice_popcount #(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = 5
) (
  input  logic [VOICES-1:0] i_vec,
  output logic [V_WIDTH:0]  o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < VOICES; i++) o_cnt = o_cnt + (V_WIDTH+1)'(i_vec[i]);
  end
endmodule

// File: rtl/voice_allocator.sv
// Maps MIDI note events onto a fixed pool of synth voices.
// An accepted event is scanned one voice per cycle against the key table,
// keys_on and voice_free; the best voice is committed after the last voice.
//   reg_clk / reset_reg_N       : clock, async active-low reset
//   ev_valid/ev_ready/ev_is_on/ev_key/ev_vel : event handshake + payload
//   all_off                      : release every gate, abort in-flight event
//   voice_free                   : per-voice envelope-decayed flags
//   keys_on, note_on, cur_*, active_keys, voice_stolen : engine-side outputs
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = $clog2(VOICES)
) (
  input  logic                reg_clk,
  input  logic                reset_reg_N,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic                ev_is_on,
  input  logic [MIDI_W-1:0]   ev_key,
  input  logic [MIDI_W-1:0]   ev_vel,
  input  logic                all_off,
  input  logic [VOICES-1:0]   voice_free,
  output logic [VOICES-1:0]   keys_on,
  output logic                note_on,
  output logic [V_WIDTH-1:0]  cur_key_adr,
  output logic [MIDI_W-1:0]   cur_key_val,
  output logic [MIDI_W-1:0]   cur_vel_on,
  output logic [MIDI_W-1:0]   cur_vel_off,
  output logic [V_WIDTH:0]    active_keys,
  output logic                voice_stolen
);
  alloc_state_t r_state, w_state_nxt;
  logic [V_WIDTH-1:0] r_idx, r_steal_ptr;
  logic [MIDI_W-1:0]  r_key_tab [VOICES];
  logic               r_is_on;
  logic [MIDI_W-1:0]  r_key, r_vel;
  // first (lowest-index) hit per category, accumulated during SCAN
  logic               r_c1_hit, r_c2_hit, r_c3_hit;
  logic [V_WIDTH-1:0] r_c1_idx, r_c2_idx, r_c3_idx;

  logic [VOICES-1:0]  r_keys_on, w_keys_nxt;
  logic [V_WIDTH:0]   r_active, w_pop;
  logic               r_note_on, r_stolen;
  logic [V_WIDTH-1:0] r_adr;
  logic [MIDI_W-1:0]  r_val, r_vel_on, r_vel_off;

  logic               w_accept, w_commit;
  alloc_cat_t         w_cat;
  logic [V_WIDTH-1:0] w_voice;
  logic               w_last;

  assign ev_ready     = (r_state == IDLE);
  assign w_accept     = ev_valid && ev_ready;
  assign w_last       = (r_idx == V_WIDTH'(VOICES-1));
  assign w_commit     = (r_state == COMMIT) && !all_off;
  assign keys_on      = r_keys_on;
  assign active_keys  = r_active;
  assign note_on      = r_note_on;
  assign voice_stolen = r_stolen;
  assign cur_key_adr  = r_adr;
  assign cur_key_val  = r_val;
  assign cur_vel_on   = r_vel_on;
  assign cur_vel_off  = r_vel_off;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SCAN;
      SCAN:    if (w_last)   w_state_nxt = COMMIT;
      COMMIT:                w_state_nxt = IDLE;
      default:               w_state_nxt = IDLE;
    endcase
    if (all_off) w_state_nxt = IDLE;
  end

  // Category resolution; note-off only ever considers a retrigger match.
  always_comb begin
    w_cat   = CAT_NONE;
    w_voice = r_steal_ptr;
    if (r_c1_hit) begin
      w_cat   = CAT_RETRIG;
      w_voice = r_c1_idx;
    end else if (r_is_on) begin
      if (r_c2_hit) begin
        w_cat   = CAT_FREE;
        w_voice = r_c2_idx;
      end else if (r_c3_hit) begin
        w_cat   = CAT_REL;
        w_voice = r_c3_idx;
      end else begin
        w_cat   = CAT_STEAL;
      end
    end
  end

  always_comb begin
    w_keys_nxt = r_keys_on;
    if (all_off)
      w_keys_nxt = '0;
    else if (w_commit && w_cat != CAT_NONE)
      w_keys_nxt[w_voice] = r_is_on;
  end

  // active_keys tracks keys_on on the same edge, so count the next value.
  voice_popcount #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) u_pop (
    .i_vec (w_keys_nxt),
    .o_cnt (w_pop)
  );

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_steal_ptr <= '0;
      for (int i = 0; i < VOICES; i++) r_key_tab[i] <= '0;
      r_is_on     <= 1'b0;
      r_key       <= '0;
      r_vel       <= '0;
      r_c1_hit    <= 1'b0;
      r_c2_hit    <= 1'b0;
      r_c3_hit    <= 1'b0;
      r_c1_idx    <= '0;
      r_c2_idx    <= '0;
      r_c3_idx    <= '0;
      r_keys_on   <= '0;
      r_active    <= '0;
      r_note_on   <= 1'b0;
      r_stolen    <= 1'b0;
      r_adr       <= '0;
      r_val       <= '0;
      r_vel_on    <= '0;
      r_vel_off   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_keys_on <= w_keys_nxt;
      r_active  <= w_pop;
      r_note_on <= 1'b0;
      r_stolen  <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_is_on  <= ev_is_on;
          r_key    <= ev_key;
          r_vel    <= ev_vel;
          r_idx    <= '0;
          r_c1_hit <= 1'b0;
          r_c2_hit <= 1'b0;
          r_c3_hit <= 1'b0;
        end
        SCAN: begin
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (!r_c1_hit && r_keys_on[r_idx] && r_key_tab[r_idx] == r_key) begin
            r_c1_hit <= 1'b1;
            r_c1_idx <= r_idx;
          end
          if (!r_c2_hit && !r_keys_on[r_idx] && voice_free[r_idx]) begin
            r_c2_hit <= 1'b1;
            r_c2_idx <= r_idx;
          end
          if (!r_c3_hit && !r_keys_on[r_idx]) begin
            r_c3_hit <= 1'b1;
            r_c3_idx <= r_idx;
          end
        end
        COMMIT: if (w_commit && w_cat != CAT_NONE) begin
          r_adr <= w_voice;
          r_val <= r_key;
          if (r_is_on) begin
            r_key_tab[w_voice] <= r_key;
            r_vel_on           <= r_vel;
            r_note_on          <= 1'b1;
            if (w_cat == CAT_STEAL) begin
              r_stolen    <= 1'b1;
              r_steal_ptr <= (r_steal_ptr == V_WIDTH'(VOICES-1)) ? '0 : r_steal_ptr + 1'b1;
            end
          end else begin
            r_vel_off <= r_vel;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation categories, stealing with
// pointer wrap, note-off, all_off abort and asynchronous reset mid-scan.
module tb_voice_allocator;
  localparam int VOICES = 32;
  localparam int VW     = 5;

  logic              reg_clk = 1'b0;
  logic              reset_reg_N = 1'b0;
  logic              ev_valid = 1'b0;
  logic              ev_ready;
  logic              ev_is_on = 1'b0;
  logic [7:0]        ev_key = '0;
  logic [7:0]        ev_vel = '0;
  logic              all_off = 1'b0;
  logic [VOICES-1:0] voice_free = '1;
  logic [VOICES-1:0] keys_on;
  logic              note_on;
  logic [VW-1:0]     cur_key_adr;
  logic [7:0]        cur_key_val, cur_vel_on, cur_vel_off;
  logic [VW:0]       active_keys;
  logic              voice_stolen;

  int n_vec = 0;
  int n_err = 0;

  voice_allocator #(.VOICES(VOICES), .V_WIDTH(VW)) dut (
    .reg_clk(reg_clk), .reset_reg_N(reset_reg_N),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_is_on(ev_is_on),
    .ev_key(ev_key), .ev_vel(ev_vel), .all_off(all_off),
    .voice_free(voice_free), .keys_on(keys_on), .note_on(note_on),
    .cur_key_adr(cur_key_adr), .cur_key_val(cur_key_val),
    .cur_vel_on(cur_vel_on), .cur_vel_off(cur_vel_off),
    .active_keys(active_keys), .voice_stolen(voice_stolen)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic tick();
    @(posedge reg_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ready, then presents the event for exactly one edge.
  task automatic start_ev(input logic on, input logic [7:0] k, input logic [7:0] v);
    int n;
    n = 0;
    while (!ev_ready && n < 50) begin tick(); n++; end
    chk("ready_before_event", ev_ready, 1);
    ev_valid = 1'b1; ev_is_on = on; ev_key = k; ev_vel = v;
    tick();
    ev_valid = 1'b0;
  endtask

  // Returns the number of edges after acceptance until ready is back.
  task automatic send_ev(input logic on, input logic [7:0] k, input logic [7:0] v, output int lat);
    start_ev(on, k, v);
    lat = 0;
    while (!ev_ready && lat < 50) begin tick(); lat++; end
  endtask

  initial begin
    int lat;
    int seen;
    #1;
    chk("rst_keys_on", keys_on, 0);
    chk("rst_note_on", note_on, 0);
    chk("rst_adr", cur_key_adr, 0);
    chk("rst_val", cur_key_val, 0);
    chk("rst_vel_on", cur_vel_on, 0);
    chk("rst_vel_off", cur_vel_off, 0);
    chk("rst_active", active_keys, 0);
    chk("rst_stolen", voice_stolen, 0);
    chk("rst_ready", ev_ready, 1);
    tick(); tick();
    reset_reg_N = 1'b1;
    tick();

    // first note-on lands on voice 0 (free)
    send_ev(1'b1, 8'd60, 8'd100, lat);
    chk("on60_latency", lat, 33);
    chk("on60_keys", keys_on, 32'h1);
    chk("on60_adr", cur_key_adr, 0);
    chk("on60_val", cur_key_val, 60);
    chk("on60_vel", cur_vel_on, 100);
    chk("on60_note_on", note_on, 1);
    chk("on60_active", active_keys, 1);
    chk("on60_stolen", voice_stolen, 0);
    tick();
    chk("on60_note_on_fall", note_on, 0);

    // retrigger of a held key
    send_ev(1'b1, 8'd60, 8'd50, lat);
    chk("retrig_keys", keys_on, 32'h1);
    chk("retrig_adr", cur_key_adr, 0);
    chk("retrig_note_on", note_on, 1);
    chk("retrig_vel", cur_vel_on, 50);
    chk("retrig_active", active_keys, 1);

    // note-off releases voice 0
    send_ev(1'b0, 8'd60, 8'd40, lat);
    chk("off60_keys", keys_on, 0);
    chk("off60_vel_off", cur_vel_off, 40);
    chk("off60_note_on", note_on, 0);
    chk("off60_active", active_keys, 0);
    chk("off60_vel_on_kept", cur_vel_on, 50);

    // voice 0 in release, voice 1 free: free wins
    voice_free = ~32'h1;
    send_ev(1'b1, 8'd70, 8'd80, lat);
    chk("c2_adr", cur_key_adr, 1);
    chk("c2_keys", keys_on, 32'h2);
    chk("c2_active", active_keys, 1);

    // nothing free: lowest releasing voice
    voice_free = '0;
    send_ev(1'b1, 8'd71, 8'd81, lat);
    chk("c3_adr", cur_key_adr, 0);
    chk("c3_keys", keys_on, 32'h3);
    chk("c3_active", active_keys, 2);

    // note-off for an unheld key changes nothing
    send_ev(1'b0, 8'd5, 8'd9, lat);
    chk("offmiss_latency", lat, 33);
    chk("offmiss_keys", keys_on, 32'h3);
    chk("offmiss_adr", cur_key_adr, 0);
    chk("offmiss_val", cur_key_val, 71);
    chk("offmiss_vel_off", cur_vel_off, 40);
    chk("offmiss_note_on", note_on, 0);

    // all_off during the scan of voice 10
    start_ev(1'b1, 8'd72, 8'd90);
    repeat (10) tick();
    all_off = 1'b1;
    tick();
    all_off = 1'b0;
    chk("alloff_keys", keys_on, 0);
    chk("alloff_active", active_keys, 0);
    chk("alloff_ready", ev_ready, 1);
    seen = 0;
    repeat (40) begin
      if (note_on) seen++;
      tick();
    end
    chk("alloff_no_note_on", seen, 0);
    chk("alloff_val_kept", cur_key_val, 71);

    // fill every voice with keys 0..31
    voice_free = '1;
    for (int k = 0; k < VOICES; k++) send_ev(1'b1, 8'(k), 8'd64, lat);
    chk("fill_keys", keys_on, 32'hFFFF_FFFF);
    chk("fill_active", active_keys, 32);
    chk("fill_adr", cur_key_adr, 31);
    chk("fill_stolen", voice_stolen, 0);

    // steals walk round-robin from voice 0
    send_ev(1'b1, 8'd99, 8'd10, lat);
    chk("steal0_adr", cur_key_adr, 0);
    chk("steal0_stolen", voice_stolen, 1);
    chk("steal0_note_on", note_on, 1);
    chk("steal0_val", cur_key_val, 99);
    chk("steal0_active", active_keys, 32);
    tick();
    chk("steal0_stolen_fall", voice_stolen, 0);
    send_ev(1'b1, 8'd98, 8'd11, lat);
    chk("steal1_adr", cur_key_adr, 1);
    chk("steal1_stolen", voice_stolen, 1);
    for (int k = 0; k < 30; k++) send_ev(1'b1, 8'(100 + k), 8'd12, lat);
    chk("steal31_adr", cur_key_adr, 31);
    chk("steal31_stolen", voice_stolen, 1);
    send_ev(1'b1, 8'd200, 8'd13, lat);
    chk("steal_wrap_adr", cur_key_adr, 0);
    chk("steal_wrap_stolen", voice_stolen, 1);
    chk("steal_wrap_keys", keys_on, 32'hFFFF_FFFF);

    // asynchronous reset in the middle of a scan
    start_ev(1'b1, 8'd77, 8'd55);
    repeat (5) tick();
    reset_reg_N = 1'b0;
    #1;
    chk("arst_keys", keys_on, 0);
    chk("arst_active", active_keys, 0);
    chk("arst_adr", cur_key_adr, 0);
    chk("arst_val", cur_key_val, 0);
    chk("arst_vel_on", cur_vel_on, 0);
    chk("arst_vel_off", cur_vel_off, 0);
    chk("arst_note_on", note_on, 0);
    chk("arst_stolen", voice_stolen, 0);
    chk("arst_ready", ev_ready, 1);
    tick();
    reset_reg_N = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
